ro_puf_ctrl: RTL and testbench

RO_PUF_CTRL -- requirements
Module: ro_puf_ctrl

---
 rtl/ro_puf_pkg.sv | 22 ++
 rtl/ro_puf_win_timer.sv | 25 ++
 rtl/ro_puf_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_ro_puf_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF controller.
// Optional build macro: RO_PUF_MAJORITY_EN (3-sample majority vote per bit).
package ro_puf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      COUNT,
      SETTLE,
      COMPARE,
      NEXT,
      DONE
   } state_t;

   localparam int CNT_W = 12;
   localparam logic [CNT_W-1:0] CNT_MAX = 12'hFFF;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/ro_puf_win_timer.sv
// Loadable 16-bit down-counter; o_expire flags the last cycle of a window.
module ro_puf_win_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_load,
   input  logic [15:0] i_val,
   input  logic        i_en,
   output logic        o_expire
);

   logic [15:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (i_en && (r_cnt != 16'd0)) begin
         r_cnt <= r_cnt - 16'd1;
      end
   end

   assign o_expire = (r_cnt == 16'd0);

endmodule

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF controller: one pairwise frequency compare per response bit.
// Optional build macro: RO_PUF_MAJORITY_EN (majority of 3 compares per bit).
module ro_puf_ctrl
   import ro_puf_pkg::*;
#(
   parameter int N_RO       = 16,
   parameter int WIN_CYCLES = 1024,
   parameter int RESP_BITS  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [$clog2(N_RO)-1:0] seed,
   output logic [$clog2(N_RO)-1:0] sel_a,
   output logic [$clog2(N_RO)-1:0] sel_b,
   output logic                    cnt_clr,
   output logic                    cnt_en,
   input  logic [CNT_W-1:0]        cnt_a,
   input  logic [CNT_W-1:0]        cnt_b,
   output logic                    busy,
   output logic                    done,
   output logic [RESP_BITS-1:0]    resp,
   output logic                    sat_err
);

   localparam int SW = $clog2(N_RO);
   localparam int KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

   state_t               r_state;
   logic [SW-1:0]        r_seed;
   logic [SW-1:0]        r_sel_a;
   logic [SW-1:0]        r_sel_b;
   logic [KW-1:0]        r_k;
   logic [RESP_BITS-1:0] r_resp;
   logic                 r_cnt_clr;
   logic                 r_cnt_en;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_sat;
`ifdef RO_PUF_MAJORITY_EN
   logic [1:0]           r_rep;
   logic [2:0]           r_votes;
`else
   logic                 r_bit;
`endif

   logic        w_expire;
   logic        w_tmr_load;
   logic [15:0] w_tmr_val;
   logic        w_tmr_en;
   logic        w_gt;
   logic        w_sat_hit;
   logic        w_bit;
   logic        w_last;
   logic [SW-1:0] w_base;

   // Timer is reused: WIN_CYCLES for COUNT, then 2 cycles for SETTLE
   always_comb begin
      w_tmr_load = (r_state == CLEAR) || ((r_state == COUNT) && w_expire);
      w_tmr_val  = (r_state == CLEAR) ? 16'(WIN_CYCLES - 1) : 16'd1;
      w_tmr_en   = (r_state == COUNT) || (r_state == SETTLE);
   end

   ro_puf_win_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_tmr_load),
      .i_val    (w_tmr_val),
      .i_en     (w_tmr_en),
      .o_expire (w_expire)
   );

   assign w_gt      = (cnt_a > cnt_b);
   assign w_sat_hit = (cnt_a == CNT_MAX) || (cnt_b == CNT_MAX);
   assign w_last    = (r_k == KW'(RESP_BITS - 1));
   assign w_base    = r_seed + SW'({r_k, 1'b0});

`ifdef RO_PUF_MAJORITY_EN
   assign w_bit = maj3(r_votes);
`else
   assign w_bit = r_bit;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_seed    <= '0;
         r_sel_a   <= '0;
         r_sel_b   <= '0;
         r_k       <= '0;
         r_resp    <= '0;
         r_cnt_clr <= 1'b1;
         r_cnt_en  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_sat     <= 1'b0;
`ifdef RO_PUF_MAJORITY_EN
         r_rep     <= '0;
         r_votes   <= '0;
`else
         r_bit     <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               r_cnt_clr <= start;
               if (start) begin
                  r_state <= CLEAR;
                  r_seed  <= seed;
                  r_sel_a <= seed;
                  r_sel_b <= seed + SW'(1);
                  r_k     <= '0;
                  r_resp  <= '0;
                  r_sat   <= 1'b0;
                  r_busy  <= 1'b1;
`ifdef RO_PUF_MAJORITY_EN
                  r_rep   <= '0;
`endif
               end
            end
            CLEAR: begin
               r_state   <= COUNT;
               r_cnt_clr <= 1'b0;
               r_cnt_en  <= 1'b1;
            end
            COUNT: begin
               if (w_expire) begin
                  r_state  <= SETTLE;
                  r_cnt_en <= 1'b0;
               end
            end
            SETTLE: begin
               if (w_expire) begin
                  r_state <= COMPARE;
               end
            end
            COMPARE: begin
               if (w_sat_hit) begin
                  r_sat <= 1'b1;
               end
`ifdef RO_PUF_MAJORITY_EN
               r_votes[r_rep] <= w_gt;
               if (r_rep == 2'd2) begin
                  r_rep   <= '0;
                  r_state <= NEXT;
               end else begin
                  r_rep     <= r_rep + 2'd1;
                  r_state   <= CLEAR;
                  r_cnt_clr <= 1'b1;
               end
`else
               r_bit   <= w_gt;
               r_state <= NEXT;
`endif
            end
            NEXT: begin
               r_resp[r_k] <= w_bit;
               r_k         <= r_k + KW'(1);
               if (w_last) begin
                  r_state <= DONE;
               end else begin
                  r_state   <= CLEAR;
                  r_cnt_clr <= 1'b1;
                  r_sel_a   <= w_base + SW'(2);
                  r_sel_b   <= w_base + SW'(3);
               end
            end
            DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign sel_a   = r_sel_a;
   assign sel_b   = r_sel_b;
   assign cnt_clr = r_cnt_clr;
   assign cnt_en  = r_cnt_en;
   assign busy    = r_busy;
   assign done    = r_done;
   assign resp    = r_resp;
   assign sat_err = r_sat;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Scoreboard bench for ro_puf_ctrl with a behavioural RO edge-counter model.
module tb_ro_puf_ctrl;

   localparam int N  = 16;
   localparam int W  = 16;
   localparam int R  = 4;
   localparam int LAT = R * (W + 5) + 1;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  seed;
   logic [3:0]  sel_a;
   logic [3:0]  sel_b;
   logic        cnt_clr;
   logic        cnt_en;
   logic [11:0] cnt_a;
   logic [11:0] cnt_b;
   logic        busy;
   logic        done;
   logic [3:0]  resp;
   logic        sat_err;

   ro_puf_ctrl #(.N_RO(N), .WIN_CYCLES(W), .RESP_BITS(R)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .seed    (seed),
      .sel_a   (sel_a),
      .sel_b   (sel_b),
      .cnt_clr (cnt_clr),
      .cnt_en  (cnt_en),
      .cnt_a   (cnt_a),
      .cnt_b   (cnt_b),
      .busy    (busy),
      .done    (done),
      .resp    (resp),
      .sat_err (sat_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Counter model: each RO has a frequency = final count after a full window
   int unsigned freq [N];
   logic [11:0] ma, mb;
   int          en_n;
   always @(posedge clk) begin
      if (cnt_clr) begin
         ma   <= '0;
         mb   <= '0;
         en_n <= 0;
      end else if (cnt_en) begin
         en_n <= en_n + 1;
         ma   <= 12'((freq[sel_a] * (en_n + 1)) / W);
         mb   <= 12'((freq[sel_b] * (en_n + 1)) / W);
      end
   end
   assign cnt_a = ma;
   assign cnt_b = mb;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
   } sel_t;
   typedef struct {
      logic [3:0] r;
      logic       s;
      int         c;
   } rsp_t;

   sel_t selq [$];
   rsp_t rspq [$];

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: sel pairs at every CLEAR pulse, result at every done pulse
   always @(negedge clk) begin
      if (!reset) begin
         if (cnt_clr && busy) begin
            if (selq.size() == 0) begin
               chk("unexpected_clear", 1, 0);
            end else begin
               sel_t e;
               e = selq.pop_front();
               chk("sel_a", int'(sel_a), int'(e.a));
               chk("sel_b", int'(sel_b), int'(e.b));
            end
         end
         if (done) begin
            if (rspq.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               rsp_t e;
               e = rspq.pop_front();
               chk("resp", int'(resp), int'(e.r));
               chk("sat_err", int'(sat_err), int'(e.s));
               chk("done_cycle", cyc, e.c);
            end
         end
      end
   end

   task automatic set_freq(input int unsigned ev, input int unsigned od);
      for (int i = 0; i < N; i++) freq[i] = (i % 2 == 0) ? ev : od;
   endtask

   // Called at a negedge; returns just after the start-sampling edge
   task automatic issue(input logic [3:0] sd, input int npairs,
                        input logic [3:0] er, input logic es,
                        input bit push_rsp);
      int t0;
      sel_t s;
      rsp_t r;
      for (int p = 0; p < npairs; p++) begin
         s.a = 4'((int'(sd) + 2 * p) % N);
         s.b = 4'((int'(sd) + 2 * p + 1) % N);
         selq.push_back(s);
      end
      seed  = sd;
      start = 1'b1;
      @(posedge clk);
      #1;
      t0    = cyc;
      start = 1'b0;
      if (push_rsp) begin
         r.r = er;
         r.s = es;
         r.c = t0 + LAT;
         rspq.push_back(r);
      end
   endtask

   task automatic wait_done();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 3 * LAT && !got; i++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      if (!got) chk("done_timeout", 0, 1);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      seed  = '0;
      set_freq(100, 90);
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_cnt_en", int'(cnt_en), 0);
      chk("rst_cnt_clr", int'(cnt_clr), 1);
      chk("rst_sel_a", int'(sel_a), 0);
      chk("rst_sel_b", int'(sel_b), 0);
      chk("rst_resp", int'(resp), 0);
      chk("rst_sat", int'(sat_err), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // a > b on every pair; a start while busy must be ignored
      issue(4'd0, R, 4'b1111, 1'b0, 1'b1);
      repeat (9) @(negedge clk);
      chk("busy_mid", int'(busy), 1);
      seed  = 4'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("idle_after", int'(busy), 0);
      end

      // wrap-around seed: pairs (14,15),(0,1),(2,3),(4,5); last pair ties
      for (int i = 0; i < N; i++) freq[i] = 60;
      freq[14] = 100; freq[15] = 90;
      freq[0]  = 30;  freq[1]  = 90;
      freq[2]  = 200; freq[3]  = 100;
      freq[4]  = 70;  freq[5]  = 70;
      issue(4'd14, R, 4'b0101, 1'b0, 1'b1);
      wait_done();
      @(negedge clk);

      // saturated RO on pair 2 (sel_a=4)
      set_freq(40, 60);
      freq[4] = 12'hFFF;
      issue(4'd0, R, 4'b0100, 1'b1, 1'b1);
      wait_done();

      // start held during the done cycle begins a new run and clears sat_err
      set_freq(50, 50);
      issue(4'd0, R, 4'b0000, 1'b0, 1'b1);
      chk("sat_cleared", int'(sat_err), 0);
      wait_done();
      repeat (2) @(negedge clk);

      // reset mid-run aborts: only pairs 0 and 1 get started
      set_freq(80, 20);
      issue(4'd3, 2, 4'b0000, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      seed  = 4'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_cnt_en", int'(cnt_en), 0);
      chk("abort_cnt_clr", int'(cnt_clr), 1);
      chk("abort_resp", int'(resp), 0);
      chk("abort_sel_a", int'(sel_a), 0);
      reset = 1'b0;
      repeat (LAT + 20) @(negedge clk);
      chk("abort_idle", int'(busy), 0);

      chk("selq_left", selq.size(), 0);
      chk("rspq_left", rspq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
